// File: rtl/phy_pkg.sv
// Shared definitions for the PHY serial receive path: byte width, comma default, FSM states.
package phy_pkg;
    localparam int                BYTE_W            = 8;
    localparam logic [BYTE_W-1:0] BC_SYMBOL_DEFAULT = 8'hBC;

    typedef enum logic {
        SEARCH = 1'b0,
        ACTIVE = 1'b1
    } rx_state_t;
endpackage

// File: rtl/rx_shift8.sv
// Serial-in shift register with a free-running mod-8 bit counter; exposes the byte completing on this edge.
module rx_shift8
    import phy_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              boundary
);
    logic [BYTE_W-1:0] shift;
    logic [2:0]        bit_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            shift   <= {shift[BYTE_W-2:0], data_in};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // The last bit is still on the line, so the full byte is visible combinationally at the boundary edge.
    assign rx_byte  = {shift[BYTE_W-2:0], data_in};
    assign boundary = (bit_cnt == 3'd7);
endmodule

// File: rtl/serie_paralelo_rx.sv
// Serial-to-byte receiver with comma alignment; RX_ERR_COUNT_EN adds an err_count port counting
// broken comma streaks seen while searching.
module serie_paralelo_rx
    import phy_pkg::*;
#(
    parameter logic [BYTE_W-1:0] BC_SYMBOL = BC_SYMBOL_DEFAULT,
    parameter int                BC_NEEDED = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active,
    output logic              byte_strobe
`ifdef RX_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);
    localparam int             BC_W   = $clog2(BC_NEEDED + 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(BC_NEEDED);

    logic [BYTE_W-1:0] rx_byte;
    logic              boundary;
    logic              is_comma;
    rx_state_t         state, state_nxt;
    logic [BC_W-1:0]   bc_cnt, bc_nxt;
    logic              valid_nxt;

    rx_shift8 u_shift (
        .clk      (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .rx_byte  (rx_byte),
        .boundary (boundary)
    );

    assign is_comma = (rx_byte == BC_SYMBOL);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state  <= SEARCH;
            bc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            bc_cnt <= bc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bc_nxt    = bc_cnt;
        if (boundary && state == SEARCH) begin
            if (is_comma) begin
                if (bc_cnt != BC_MAX) bc_nxt = bc_cnt + 1'b1;
            end else begin
                bc_nxt = '0;
            end
            if (bc_nxt == BC_MAX) state_nxt = ACTIVE;
        end
    end

    // Uses the pre-edge state so the comma that completes alignment is never reported.
    assign valid_nxt = (state == ACTIVE) && !is_comma;
    assign active    = (state == ACTIVE);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            data_out    <= '0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
        end else begin
            byte_strobe <= boundary;
            if (boundary) begin
                valid_out <= valid_nxt;
                if (valid_nxt) data_out <= rx_byte;
            end
        end
    end

`ifdef RX_ERR_COUNT_EN
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (boundary && state == SEARCH && bc_cnt != '0 && !is_comma
                     && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif
endmodule
